// File: rtl/fir_share_arbiter.sv
// Packet-granular round-robin sharing of one AXI-Stream filter between NUM_CH sources.
// Returned filter packets are steered back to their source port by an in-order tag FIFO.
module fir_share_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                         s00_axis_aclk,
    input  logic                         s00_axis_aresetn,
    input  logic [NUM_CH-1:0]            s_axis_tvalid,
    input  logic [NUM_CH-1:0]            s_axis_tlast,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
    output logic [NUM_CH-1:0]            s_axis_tready,
    output logic                         f_axis_tvalid,
    output logic                         f_axis_tlast,
    output logic [DATA_WIDTH-1:0]        f_axis_tdata,
    input  logic                         f_axis_tready,
    input  logic                         r_axis_tvalid,
    input  logic                         r_axis_tlast,
    input  logic [DATA_WIDTH-1:0]        r_axis_tdata,
    output logic                         r_axis_tready,
    output logic [NUM_CH-1:0]            m_axis_tvalid,
    output logic [NUM_CH-1:0]            m_axis_tlast,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    input  logic [NUM_CH-1:0]            m_axis_tready,
    output logic                         busy,
    output logic [$clog2(NUM_CH)-1:0]    cur_ch,
    output logic                         err_orphan
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam logic [CH_W:0]  NUM_CH_W = (CH_W+1)'(NUM_CH);
    localparam logic [PTR_W:0] DEPTH_W  = (PTR_W+1)'(TAG_DEPTH);

    typedef enum logic {ST_IDLE, ST_STREAM} state_t;

    state_t           state_q, state_d;
    logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]  cur_ch_q, cur_ch_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             err_orphan_q, err_orphan_d;
    logic [CH_W-1:0]  tag_mem [TAG_DEPTH];

    logic [DATA_WIDTH-1:0] s_data_arr [NUM_CH];
    logic [2*NUM_CH-1:0]   req_dbl;
    logic [NUM_CH-1:0]     req_rot;
    logic [CH_W-1:0]       sel_off, sel;
    logic [CH_W:0]         sel_sum;
    logic                  sel_valid;
    logic                  tag_full, tag_empty;
    logic [CH_W-1:0]       head_tag;
    logic                  push, pop, f_last_beat, r_beat;

    assign tag_full  = (count_q == DEPTH_W);
    assign tag_empty = (count_q == '0);
    assign head_tag  = tag_mem[rd_ptr_q];

    // Rotate requests so bit 0 is rr_ptr, take the lowest set bit, then rotate the index back.
    always_comb begin
        req_dbl   = {s_axis_tvalid, s_axis_tvalid} >> rr_ptr_q;
        req_rot   = req_dbl[NUM_CH-1:0];
        sel_off   = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!sel_valid && req_rot[i]) begin
                sel_valid = 1'b1;
                sel_off   = CH_W'(i);
            end
        end
        sel_sum = {1'b0, rr_ptr_q} + {1'b0, sel_off};
        if (sel_sum >= NUM_CH_W) begin
            sel_sum = sel_sum - NUM_CH_W;
        end
        sel = sel_sum[CH_W-1:0];
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign s_data_arr[gi]    = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign s_axis_tready[gi] = (state_q == ST_STREAM) && (cur_ch_q == CH_W'(gi)) && f_axis_tready;
        assign m_axis_tvalid[gi] = !tag_empty && (head_tag == CH_W'(gi)) && r_axis_tvalid;
        assign m_axis_tlast[gi]  = !tag_empty && (head_tag == CH_W'(gi)) && r_axis_tlast;
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (sel_valid && !tag_full) state_d = ST_STREAM;
            ST_STREAM: if (f_last_beat) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        f_axis_tvalid = 1'b0;
        f_axis_tlast  = 1'b0;
        f_axis_tdata  = s_data_arr[cur_ch_q];
        if (state_q == ST_STREAM) begin
            f_axis_tvalid = s_axis_tvalid[cur_ch_q];
            f_axis_tlast  = s_axis_tlast[cur_ch_q];
        end
    end

    assign f_last_beat = f_axis_tvalid && f_axis_tready && f_axis_tlast;
    assign push        = (state_q == ST_IDLE) && sel_valid && !tag_full;

    // With no packet outstanding the return path sinks everything; held low while in reset.
    assign r_axis_tready = s00_axis_aresetn && (tag_empty ? 1'b1 : m_axis_tready[head_tag]);
    assign r_beat        = r_axis_tvalid && r_axis_tready;
    assign pop           = r_beat && r_axis_tlast && !tag_empty;
    assign m_axis_tdata  = r_axis_tdata;

    always_comb begin
        cur_ch_d     = push ? sel : cur_ch_q;
        rr_ptr_d     = rr_ptr_q;
        if (f_last_beat) begin
            rr_ptr_d = (cur_ch_q == CH_W'(NUM_CH-1)) ? '0 : cur_ch_q + 1'b1;
        end
        wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d      = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        err_orphan_d = err_orphan_q || (r_beat && tag_empty);
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            rr_ptr_q     <= '0;
            cur_ch_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            cur_ch_q     <= cur_ch_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    // Tag storage needs no reset: entries are only read while count_q marks them valid.
    always_ff @(posedge s00_axis_aclk) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= sel;
        end
    end

    assign busy       = (state_q == ST_STREAM);
    assign cur_ch     = cur_ch_q;
    assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_fir_share_arbiter.sv
// Directed bench for fir_share_arbiter: cycle table for arbitration/tag-full, then
// loopback-filter sequences for fairness, return routing, backpressure, orphan and reset.
module tb_fir_share_arbiter;
    localparam int NC  = 4;
    localparam int DW  = 32;
    localparam int TD  = 4;
    localparam int LAT = 15;
    localparam int NV  = 26;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [NC-1:0]  s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [NC*DW-1:0] s_axis_tdata;
    logic           f_axis_tvalid, f_axis_tlast, f_axis_tready;
    logic [DW-1:0]  f_axis_tdata;
    logic           r_axis_tvalid, r_axis_tlast, r_axis_tready;
    logic [DW-1:0]  r_axis_tdata;
    logic [NC-1:0]  m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [DW-1:0]  m_axis_tdata;
    logic           busy, err_orphan;
    logic [1:0]     cur_ch;

    fir_share_arbiter #(.NUM_CH(NC), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tdata(s_axis_tdata), .s_axis_tready(s_axis_tready),
        .f_axis_tvalid(f_axis_tvalid), .f_axis_tlast(f_axis_tlast),
        .f_axis_tdata(f_axis_tdata), .f_axis_tready(f_axis_tready),
        .r_axis_tvalid(r_axis_tvalid), .r_axis_tlast(r_axis_tlast),
        .r_axis_tdata(r_axis_tdata), .r_axis_tready(r_axis_tready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tready(m_axis_tready),
        .busy(busy), .cur_ch(cur_ch), .err_orphan(err_orphan)
    );

    typedef struct {
        logic [3:0] sv, sl; logic fr, rv, rl; logic [3:0] mr;
        logic fv, fl; logic [3:0] sr; logic bz; logic [1:0] cc; logic rr; logic [3:0] mv;
    } vec_t;
    vec_t tbl [NV];

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int k = 0;
    int src_len [NC];
    int src_seq [NC];
    int m_seq [NC];
    int m_beats [NC];
    int m_total, stall_seen;
    int f_lo, f_hi, m_lo, m_hi;
    logic busy_prev;
    logic [DW-1:0] lb_d [$];
    logic          lb_l [$];
    int            lb_t [$];
    int            grants [$];
    int            m_ord [$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] chdata(input int c);
        return {8'(c), 8'hA5, 16'h0000};
    endfunction

    function automatic int get_g(input int i);
        return (i < grants.size()) ? grants[i] : 99;
    endfunction

    function automatic int get_o(input int i);
        return (i < m_ord.size()) ? m_ord[i] : 99;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tdata = '0; f_axis_tready = 1'b0;
        r_axis_tvalid = 1'b0; r_axis_tlast = 1'b0; r_axis_tdata = '0; m_axis_tready = '0;
        for (int c = 0; c < NC; c++) begin
            src_len[c] = 0; src_seq[c] = 0; m_seq[c] = 0; m_beats[c] = 0;
        end
        lb_d.delete(); lb_l.delete(); lb_t.delete(); grants.delete(); m_ord.delete();
        busy_prev = 1'b0; m_total = 0; stall_seen = 0; k = 0;
        f_lo = -1; f_hi = -1; m_lo = -1; m_hi = -1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle of sources, loopback filter (fixed latency) and sinks around the DUT.
    task automatic model_cycle();
        logic [NC-1:0] s_hs;
        logic          f_hs, r_hs, m_acc, bad;
        logic [DW-1:0] f_d;
        logic          f_l;
        logic [1:0]    mi;
        logic [3:0]    oh;
        @(negedge clk);
        for (int c = 0; c < NC; c++) begin
            s_axis_tvalid[c] = (src_len[c] > 0);
            s_axis_tlast[c]  = (src_len[c] == 1);
            s_axis_tdata[c*DW +: DW] = {8'(c), 8'h5A, 16'(src_seq[c])};
        end
        f_axis_tready = !(k >= f_lo && k < f_hi);
        m_axis_tready = (k >= m_lo && k < m_hi) ? 4'b1101 : 4'b1111;
        if (lb_d.size() > 0 && cyc >= lb_t[0] + LAT) begin
            r_axis_tvalid = 1'b1; r_axis_tdata = lb_d[0]; r_axis_tlast = lb_l[0];
        end else begin
            r_axis_tvalid = 1'b0; r_axis_tdata = '0; r_axis_tlast = 1'b0;
        end
        #1;
        s_hs = s_axis_tvalid & s_axis_tready;
        f_hs = f_axis_tvalid && f_axis_tready;
        r_hs = r_axis_tvalid && r_axis_tready;
        f_d  = f_axis_tdata;
        f_l  = f_axis_tlast;
        if (f_hs || s_hs != '0) begin
            bad = !f_hs || ($countones(s_hs) != 1);
            for (int c = 0; c < NC; c++)
                if (s_hs[c] && (f_d !== s_axis_tdata[c*DW +: DW] || f_l !== s_axis_tlast[c])) bad = 1'b1;
            nchk++;
            if (bad) begin
                nerr++;
                $display("FAIL fwd_beat f_hs=%b s_hs=%b f_data=%h", f_hs, s_hs, f_d);
            end
        end
        m_acc = 1'b0;
        mi = m_axis_tdata[25:24];
        if (m_axis_tvalid != '0) begin
            oh = 4'b0001 << mi;
            nchk++;
            if (m_axis_tdata[31:26] != 6'd0 || m_axis_tvalid != oh ||
                r_axis_tready !== m_axis_tready[mi] || m_axis_tlast[mi] !== r_axis_tlast) begin
                nerr++;
                $display("FAIL m_route m_tvalid=%b data=%h r_tready=%b m_tready=%b", m_axis_tvalid, m_axis_tdata, r_axis_tready, m_axis_tready);
            end else if (!m_axis_tready[mi]) begin
                stall_seen++;
            end else begin
                m_acc = 1'b1;
                chk($sformatf("m_seq_ch%0d", mi), {16'h0, m_axis_tdata[15:0]}, 32'(m_seq[mi]));
                $display("return beat ch%0d data=%h last=%b", mi, m_axis_tdata, r_axis_tlast);
            end
        end
        if (busy && !busy_prev) begin
            grants.push_back(int'(cur_ch));
            $display("grant ch%0d at cycle %0d", cur_ch, cyc);
        end
        busy_prev = busy;
        @(posedge clk);
        cyc++;
        k++;
        for (int c = 0; c < NC; c++)
            if (s_hs[c]) begin src_len[c]--; src_seq[c]++; end
        if (f_hs) begin lb_d.push_back(f_d); lb_l.push_back(f_l); lb_t.push_back(cyc); end
        if (r_hs && lb_d.size() > 0) begin
            void'(lb_d.pop_front()); void'(lb_l.pop_front()); void'(lb_t.pop_front());
        end
        if (m_acc) begin
            m_seq[mi]++; m_beats[mi]++; m_total++; m_ord.push_back(int'(mi));
        end
    endtask

    task automatic run_until(input int expect_total, input int budget, input string name);
        int n;
        n = 0;
        while ((src_len[0] + src_len[1] + src_len[2] + src_len[3] > 0 || m_total < expect_total) && n < budget) begin
            model_cycle();
            n++;
        end
        nchk++;
        if (n >= budget) begin
            nerr++;
            $display("FAIL %s_timeout returned=%0d required=%0d", name, m_total, expect_total);
        end
    endtask

    task automatic wait_busy(input string name);
        int n;
        n = 0;
        while (!busy_prev && n < 10) begin model_cycle(); n++; end
        chk({name, "_granted"}, busy_prev, 1);
    endtask

    task automatic check_empty(input string name);
        @(negedge clk);
        s_axis_tvalid = '0; r_axis_tvalid = 1'b0; m_axis_tready = '0;
        #1;
        chk({name, "_tags_empty"}, r_axis_tready, 1);
        chk({name, "_no_orphan"}, err_orphan, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Inputs: sv sl fr rv rl mr | expected: fv fl sr bz cc rr mv
        tbl[0]  = '{4'hF,4'h0,1,0,0,4'hF, 0,0,4'h0,0,2'd0,1,4'h0};
        tbl[1]  = '{4'hF,4'h0,1,0,0,4'hF, 1,0,4'h1,1,2'd0,1,4'h0};
        tbl[2]  = '{4'hF,4'h0,1,0,0,4'hF, 1,0,4'h1,1,2'd0,1,4'h0};
        tbl[3]  = '{4'hF,4'h1,1,0,0,4'hF, 1,1,4'h1,1,2'd0,1,4'h0};
        tbl[4]  = '{4'hF,4'h0,1,0,0,4'hF, 0,0,4'h0,0,2'd0,1,4'h0};
        tbl[5]  = '{4'hF,4'h0,1,0,0,4'hF, 1,0,4'h2,1,2'd1,1,4'h0};
        tbl[6]  = '{4'hF,4'h0,1,0,0,4'hF, 1,0,4'h2,1,2'd1,1,4'h0};
        tbl[7]  = '{4'hF,4'h2,1,0,0,4'hF, 1,1,4'h2,1,2'd1,1,4'h0};
        tbl[8]  = '{4'hF,4'h0,1,0,0,4'hF, 0,0,4'h0,0,2'd1,1,4'h0};
        tbl[9]  = '{4'hF,4'h0,1,0,0,4'hF, 1,0,4'h4,1,2'd2,1,4'h0};
        tbl[10] = '{4'hF,4'h0,1,0,0,4'hF, 1,0,4'h4,1,2'd2,1,4'h0};
        tbl[11] = '{4'hF,4'h4,1,0,0,4'hF, 1,1,4'h4,1,2'd2,1,4'h0};
        tbl[12] = '{4'hF,4'h0,1,0,0,4'hF, 0,0,4'h0,0,2'd2,1,4'h0};
        tbl[13] = '{4'hF,4'h0,1,0,0,4'hF, 1,0,4'h8,1,2'd3,1,4'h0};
        tbl[14] = '{4'hF,4'h0,1,0,0,4'hF, 1,0,4'h8,1,2'd3,1,4'h0};
        tbl[15] = '{4'hF,4'h8,1,0,0,4'hF, 1,1,4'h8,1,2'd3,1,4'h0};
        tbl[16] = '{4'hF,4'h0,1,0,0,4'hF, 0,0,4'h0,0,2'd3,1,4'h0};
        tbl[17] = '{4'hF,4'h0,1,1,0,4'hF, 0,0,4'h0,0,2'd3,1,4'h1};
        tbl[18] = '{4'hF,4'h0,1,1,1,4'hF, 0,0,4'h0,0,2'd3,1,4'h1};
        tbl[19] = '{4'hF,4'h0,1,0,0,4'hF, 0,0,4'h0,0,2'd3,1,4'h0};
        tbl[20] = '{4'hF,4'h1,1,1,1,4'hD, 1,1,4'h1,1,2'd0,0,4'h2};
        tbl[21] = '{4'hF,4'h0,1,1,1,4'hF, 0,0,4'h0,0,2'd0,1,4'h2};
        tbl[22] = '{4'hF,4'h0,1,0,0,4'hF, 0,0,4'h0,0,2'd0,1,4'h0};
        tbl[23] = '{4'hF,4'h0,0,0,0,4'hF, 1,0,4'h0,1,2'd1,1,4'h0};
        tbl[24] = '{4'hF,4'h2,1,0,0,4'hF, 1,1,4'h2,1,2'd1,1,4'h0};
        tbl[25] = '{4'hF,4'h0,1,0,0,4'hF, 0,0,4'h0,0,2'd1,1,4'h0};

        rst_n = 1'b0;
        s_axis_tvalid = 4'hF; s_axis_tlast = 4'hF; s_axis_tdata = '0; f_axis_tready = 1'b1;
        r_axis_tvalid = 1'b1; r_axis_tlast = 1'b1; r_axis_tdata = '0; m_axis_tready = 4'hF;
        #2;
        chk("rst_f_tvalid", f_axis_tvalid, 0);
        chk("rst_s_tready", s_axis_tready, 0);
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_r_tready", r_axis_tready, 0);
        chk("rst_busy_curch", {busy, cur_ch}, 0);
        chk("rst_err", err_orphan, 0);
        r_axis_tvalid = 1'b0; r_axis_tlast = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < NC; c++) s_axis_tdata[c*DW +: DW] = chdata(c);

        for (int i = 0; i < NV; i++) begin
            s_axis_tvalid = tbl[i].sv; s_axis_tlast = tbl[i].sl; f_axis_tready = tbl[i].fr;
            r_axis_tvalid = tbl[i].rv; r_axis_tlast = tbl[i].rl; m_axis_tready = tbl[i].mr;
            r_axis_tdata  = 32'hBEEF_0000 + 32'(i);
            #1;
            chk($sformatf("v%0d_f_valid_last", i), {f_axis_tvalid, f_axis_tlast}, {tbl[i].fv, tbl[i].fl});
            chk($sformatf("v%0d_s_tready", i), s_axis_tready, tbl[i].sr);
            chk($sformatf("v%0d_busy_curch", i), {busy, cur_ch}, {tbl[i].bz, tbl[i].cc});
            chk($sformatf("v%0d_r_tready", i), r_axis_tready, tbl[i].rr);
            chk($sformatf("v%0d_m_tvalid", i), m_axis_tvalid, tbl[i].mv);
            chk($sformatf("v%0d_m_tdata", i), m_axis_tdata, 32'hBEEF_0000 + 32'(i));
            if (tbl[i].fv) chk($sformatf("v%0d_f_tdata", i), f_axis_tdata, chdata(int'(tbl[i].cc)));
            $display("vector %0d applied: busy=%b cur_ch=%0d s_tready=%b m_tvalid=%b", i, busy, cur_ch, s_axis_tready, m_axis_tvalid);
            @(negedge clk);
        end

        // Fairness after wrap: ch2 alone first, then ch1 and ch3 compete.
        do_reset();
        src_len[2] = 2;
        wait_busy("fair");
        src_len[1] = 2; src_len[3] = 2;
        run_until(6, 300, "fair");
        chk("fair_ngrants", grants.size(), 3);
        chk("fair_g0", get_g(0), 2);
        chk("fair_g1", get_g(1), 3);
        chk("fair_g2", get_g(2), 1);
        chk("fair_beats_ch3", m_beats[3], 2);
        check_empty("fair");

        // Return routing with filter and sink backpressure.
        do_reset();
        f_lo = 4; f_hi = 9; m_lo = 18; m_hi = 30;
        src_len[1] = 4; src_len[3] = 4;
        run_until(8, 400, "route");
        chk("route_ngrants", grants.size(), 2);
        chk("route_g0", get_g(0), 1);
        chk("route_g1", get_g(1), 3);
        chk("route_beats_ch1", m_beats[1], 4);
        chk("route_beats_ch3", m_beats[3], 4);
        for (int i = 0; i < 8; i++) chk($sformatf("route_order%0d", i), get_o(i), (i < 4) ? 1 : 3);
        chk("route_stall_seen", (stall_seen > 0), 1);
        check_empty("route");

        // Orphan return beat, then asynchronous reset in the middle of a packet.
        do_reset();
        @(negedge clk);
        r_axis_tvalid = 1'b1; r_axis_tlast = 1'b0; r_axis_tdata = 32'h0BAD_0001; m_axis_tready = '0;
        #1;
        chk("orphan_r_tready", r_axis_tready, 1);
        chk("orphan_m_tvalid", m_axis_tvalid, 0);
        chk("orphan_err_before", err_orphan, 0);
        @(negedge clk);
        r_axis_tvalid = 1'b0;
        #1;
        chk("orphan_err_after", err_orphan, 1);
        src_len[2] = 6;
        wait_busy("midrst");
        model_cycle();
        model_cycle();
        #2;
        chk("midrst_pre_busy_curch", {busy, cur_ch}, {1'b1, 2'd2});
        chk("midrst_pre_r_tready", r_axis_tready, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_f_tvalid", f_axis_tvalid, 0);
        chk("midrst_s_tready", s_axis_tready, 0);
        chk("midrst_m_tvalid", m_axis_tvalid, 0);
        chk("midrst_r_tready", r_axis_tready, 0);
        chk("midrst_busy_curch", {busy, cur_ch}, 0);
        chk("midrst_err", err_orphan, 0);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/fir_share_arbiter.md
Name: fir_share_arbiter

Overview:
- Time-shares one fir_15-class AXI-Stream filter between NUM_CH audio sources at packet granularity.
- Round-robin picks a source and forwards its whole packet (through tlast) to the filter.
- Filter output packets are routed back to the matching per-channel master port via an in-order channel-tag FIFO.
- Sits between the per-channel capture/DMA streams and the shared filter instance.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- DATA_WIDTH, 32, tdata width on all streams.
- TAG_DEPTH, 4, packets allowed in flight inside the filter (power of 2).

Ports:
- s00_axis_aclk  in  1  single clock for all interfaces.
- s00_axis_aresetn  in  1  asynchronous active-low reset.
- s_axis_tvalid  in  NUM_CH  per-channel source valid.
- s_axis_tlast  in  NUM_CH  per-channel end of packet.
- s_axis_tdata  in  NUM_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tready  out  NUM_CH  per-channel ready.
- f_axis_tvalid / f_axis_tlast  out  1  stream into the filter.
- f_axis_tdata  out  DATA_WIDTH  stream into the filter.
- f_axis_tready  in  1  filter ready.
- r_axis_tvalid / r_axis_tlast  in  1  filter output stream.
- r_axis_tdata  in  DATA_WIDTH  filter output data.
- r_axis_tready  out  1  ready to filter output.
- m_axis_tvalid / m_axis_tlast  out  NUM_CH  per-channel filtered output.
- m_axis_tdata  out  DATA_WIDTH  shared data bus; qualified by m_axis_tvalid[c].
- m_axis_tready  in  NUM_CH  per-channel sink ready.
- busy  out  1  high in STREAM.
- cur_ch  out  $clog2(NUM_CH)  granted channel; valid while busy.
- err_orphan  out  1  sticky: filter output arrived with no tag.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr_ptr=0, tag FIFO empty, err_orphan=0.
  - All tvalid/tready outputs 0; cur_ch=0; busy=0.
- State IDLE:
  - When any s_axis_tvalid is set and the tag FIFO is not full, select the first requester at or after rr_ptr (wrapping).
  - Registered on the next edge: cur_ch=sel, push sel into the tag FIFO, state -> STREAM.
  - No data moves in the decision cycle (1-cycle arbitration latency).
- State STREAM (combinational pass-through):
  - f_axis_tvalid = s_axis_tvalid[cur_ch]; f_axis_tdata and f_axis_tlast come from cur_ch.
  - s_axis_tready[cur_ch] = f_axis_tready; all other s_axis_tready = 0.
  - On a beat with f_axis_tvalid & f_axis_tready & f_axis_tlast: rr_ptr = cur_ch+1 (mod NUM_CH), state -> IDLE.
  - The grant is never revoked mid-packet; other requesters wait.
- Return path:
  - When the tag FIFO is non-empty with head tag t: m_axis_tvalid[t] = r_axis_tvalid, m_axis_tlast[t] = r_axis_tlast, r_axis_tready = m_axis_tready[t]; all other m_axis_tvalid = 0.
  - m_axis_tdata = r_axis_tdata at all times.
  - Pop the tag on an accepted beat with r_axis_tlast.
- Orphan output:
  - With the tag FIFO empty: r_axis_tready = 1 and the data is dropped.
  - An accepted r_axis_tvalid beat in this condition sets err_orphan, which stays set until reset.
- Tag FIFO:
  - Push and pop on the same edge are both performed; count is unchanged.
  - A full FIFO blocks new grants only; in-progress STREAM and return traffic are unaffected.
- Boundary cases:
  - Single-beat packet (tvalid and tlast together) is a legal full grant.
  - A requester deasserting tvalid mid-packet keeps the grant; f_axis_tvalid drops with it.
  - A lone requester is re-granted after each packet with one idle cycle between packets.
- Reset mid-packet:
  - Everything clears immediately; the partial packet is abandoned.
  - The filter shares this reset and must be reset with it.

Test Plan:
- Four-way round-robin:
  - Stimulus: ch0..ch3 each hold a 3-beat packet from reset.
  - Required: grants in order 0,1,2,3; f_axis carries 12 beats with tlast on beats 3/6/9/12; one idle cycle between packets.
- Fairness after wrap:
  - Stimulus: ch2 finishes a packet; ch1 and ch3 are both requesting.
  - Required: ch3 is granted next, then ch1.
- Return routing:
  - Stimulus: loopback filter model with 15-cycle latency; packets from ch1 then ch3.
  - Required: ch1 data appears only on m_axis_tvalid[1], then ch3 data only on m_axis_tvalid[3]; the tag FIFO ends empty.
- Backpressure:
  - Stimulus: hold f_axis_tready=0 for 5 cycles mid-packet; separately hold m_axis_tready[1]=0.
  - Required: no beat is lost or duplicated; r_axis_tready follows m_axis_tready[1].
- Tag-full stall:
  - Stimulus: TAG_DEPTH=4 with the filter output stalled; 5 single-beat packets offered.
  - Required: 4 grants are issued and the 5th waits in IDLE until the first return tlast pops a tag.
- Orphan and reset:
  - Stimulus: r_axis_tvalid=1 with no packets sent.
  - Required: beat accepted, err_orphan=1 from the next cycle.
  - Stimulus: assert reset mid-STREAM.
  - Required: all outputs 0 without waiting for a clock edge; err_orphan=0.
